// File: rtl/ws2812_pkg.sv
// ws2812_pkg: constants, cycle-count helpers and rx state encoding shared by
// the ws2812 transmitter and receiver. All timings derive from the clock
// frequency in MHz; fractional cycle counts round up.
package ws2812_pkg;

  localparam int BITS_PER_LED = 24;

  function automatic int ns_to_cyc(input int clk_mhz, input int ns);
    return (clk_mhz * ns + 999) / 1000;
  endfunction

  // Transmitter bit timing: 1.25 us period, 0.8 us high for '1', 0.4 us for '0'.
  function automatic int t_period(input int clk_mhz);
    return ns_to_cyc(clk_mhz, 1250);
  endfunction
  function automatic int t_on(input int clk_mhz);
    return ns_to_cyc(clk_mhz, 800);
  endfunction
  function automatic int t_off(input int clk_mhz);
    return ns_to_cyc(clk_mhz, 400);
  endfunction

  // Latch gap: 50 us of low ends a frame.
  function automatic int t_gap(input int clk_mhz);
    return clk_mhz * 50;
  endfunction

  // Receiver decode limits.
  function automatic int t_min(input int clk_mhz);
    return ns_to_cyc(clk_mhz, 150);
  endfunction
  function automatic int t_thresh(input int clk_mhz);
    return ns_to_cyc(clk_mhz, 600);
  endfunction
  function automatic int t_high_max(input int clk_mhz);
    return clk_mhz * 5;
  endfunction

  typedef enum logic [1:0] {
    RX_SYNC = 2'd0,
    RX_IDLE = 2'd1,
    RX_HIGH = 2'd2,
    RX_LOW  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/ws2812_rx_sync.sv
// ws2812_rx_sync: 2-flop synchroniser for an asynchronous serial line plus a
// registered rise/fall detector.
//   clk, reset_n : clock, synchronous active-low reset
//   din          : asynchronous input line
//   level        : synchronised line level
//   rise, fall   : one-cycle edge flags, one cycle behind level
module ws2812_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 serial stream into 24-bit words using the same
// write/led_num/rgb_data interface as the transmitter input.
//   clk, reset_n : clock, synchronous active-low reset
//   din          : asynchronous serial line
//   rgb_data     : decoded word (MSB first on the wire), valid while write=1
//   led_num      : index of the word within the frame
//   write        : strobe per decoded word with index < NUM_LEDS
//   frame_done   : strobe when a gap ends a frame holding at least one bit
//   frame_err    : strobe on glitch, overlong high or partial word at gap
//   synced       : a full gap has been seen since reset / last error
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int CLK_MHZ  = 12,
  parameter int NUM_LEDS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        write,
  output logic        frame_done,
  output logic        frame_err,
  output logic        synced
);

  localparam int GAP   = t_gap(CLK_MHZ);
  localparam int CNT_W = $clog2(GAP + 1);

  localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] C_MIN  = CNT_W'(t_min(CLK_MHZ));
  localparam logic [CNT_W-1:0] C_THR  = CNT_W'(t_thresh(CLK_MHZ));
  localparam logic [CNT_W-1:0] C_HMAX = CNT_W'(t_high_max(CLK_MHZ));
  localparam logic [4:0]       LAST_BIT = 5'(BITS_PER_LED - 1);

  logic level, rise, fall;

  ws2812_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;       // low count in SYNC/LOW, high width in HIGH
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic [23:0]       shreg_q, shreg_d;
  logic [23:0]       rgb_q, rgb_d;
  logic [7:0]        led_num_q, led_num_d;
  logic              write_q, write_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              synced_q, synced_d;

  logic [CNT_W-1:0]  cnt_inc;

  // Saturating increment; in HIGH this is the width including the current
  // cycle, so a pulse sampled high for N cycles measures N at its fall.
  assign cnt_inc = (cnt_q == C_GAP) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shreg_d    = shreg_q;
    rgb_d      = rgb_q;
    led_num_d  = led_num_q;
    write_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    synced_d   = synced_q;

    unique case (state_q)
      RX_SYNC: begin
        synced_d = 1'b0;
        if (level) begin
          cnt_d = '0;
        end else if (cnt_q == C_GAP) begin
          state_d  = RX_IDLE;
          synced_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RX_IDLE: begin
        if (rise) begin
          state_d = RX_HIGH;
          cnt_d   = '0;
        end
      end

      RX_HIGH: begin
        cnt_d = cnt_inc;
        if (cnt_inc > C_HMAX || (fall && cnt_inc < C_MIN)) begin
          // Stuck line or glitch: drop the frame and wait for a clean gap.
          state_d    = RX_SYNC;
          cnt_d      = '0;
          err_d      = 1'b1;
          synced_d   = 1'b0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end else if (fall) begin
          shreg_d = {shreg_q[22:0], (cnt_inc >= C_THR)};
          state_d = RX_LOW;
          cnt_d   = '0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            word_cnt_d = (word_cnt_q == 8'hFF) ? word_cnt_q : word_cnt_q + 8'd1;
            if (int'(word_cnt_q) < NUM_LEDS) begin
              write_d   = 1'b1;
              rgb_d     = shreg_d;
              led_num_d = word_cnt_q;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      RX_LOW: begin
        // Gap expiry beats a simultaneous rise; that rise is dropped.
        if (cnt_q == C_GAP) begin
          done_d     = 1'b1;
          err_d      = (bit_cnt_q != '0);
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = RX_IDLE;
          cnt_d      = '0;
        end else if (rise) begin
          state_d = RX_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: state_d = RX_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= RX_SYNC;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shreg_q    <= '0;
      rgb_q      <= '0;
      led_num_q  <= '0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      synced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shreg_q    <= shreg_d;
      rgb_q      <= rgb_d;
      led_num_q  <= led_num_d;
      write_q    <= write_d;
      done_q     <= done_d;
      err_q      <= err_d;
      synced_q   <= synced_d;
    end
  end

  assign rgb_data   = rgb_q;
  assign led_num    = led_num_q;
  assign write      = write_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign synced     = synced_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx at CLK_MHZ=12, NUM_LEDS=8. Inputs change on
// the falling clock edge; outputs are sampled on the falling edge.
module tb_ws2812_rx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        din;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        write;
  logic        frame_done;
  logic        frame_err;
  logic        synced;

  ws2812_rx #(.CLK_MHZ(12), .NUM_LEDS(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .rgb_data   (rgb_data),
    .led_num    (led_num),
    .write      (write),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .synced     (synced)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [23:0] wr_data[$];
  logic [7:0]  wr_num[$];
  int fd_cnt = 0, fe_cnt = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (write) begin
      wr_data.push_back(rgb_data);
      wr_num.push_back(led_num);
    end
    if (frame_done) fd_cnt++;
    if (frame_err) fe_cnt++;
    if (frame_done && frame_err) both_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(10, 5);
    else   pulse(5, 10);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic gap();
    din = 1'b0;
    repeat (650) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_data.delete();
    wr_num.delete();
  endtask

  typedef struct {
    logic [23:0] word;
    logic [7:0]  num;
  } word_vec_t;

  typedef struct {
    int   hi;
    logic bit_v;
  } width_vec_t;

  localparam logic [22:0] PAT = 23'h2B5A4C;

  word_vec_t  wv[8];
  width_vec_t bv[8];
  int fd0, fe0, n;
  logic [23:0] lw;

  initial begin
    wv[0] = '{24'hFF0000, 8'd0}; wv[1] = '{24'h00FF00, 8'd1};
    wv[2] = '{24'h0000FF, 8'd2}; wv[3] = '{24'hFFFFFF, 8'd3};
    wv[4] = '{24'h000000, 8'd4}; wv[5] = '{24'hA5C3E1, 8'd5};
    wv[6] = '{24'h123456, 8'd6}; wv[7] = '{24'h000001, 8'd7};
    bv[0] = '{2, 1'b0};  bv[1] = '{5, 1'b0};  bv[2] = '{7, 1'b0};
    bv[3] = '{8, 1'b1};  bv[4] = '{11, 1'b1}; bv[5] = '{59, 1'b1};
    bv[6] = '{60, 1'b1}; bv[7] = '{3, 1'b0};

    // 1: reset state, then sync after a full low gap
    reset_n = 1'b0;
    din     = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_write", write, 0);
    chk("rst_synced", synced, 0);
    chk("rst_rgb", rgb_data, 0);
    chk("rst_flags", {frame_done, frame_err, led_num}, 0);
    reset_n = 1'b1;
    n = 0;
    while (!synced && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk("sync_time_window", (n >= 600 && n <= 603), 1);
    chk("sync_no_done", fd_cnt, 0);
    chk("sync_no_write", wr_data.size(), 0);

    // 2: eight-word frame
    clear_log();
    fd0 = fd_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 8; i++) send_word(wv[i].word);
    gap();
    chk("frame8_writes", wr_data.size(), 8);
    for (int i = 0; i < 8 && i < wr_data.size(); i++) begin
      chk($sformatf("frame8_data%0d", i), wr_data[i], wv[i].word);
      chk($sformatf("frame8_num%0d", i), wr_num[i], wv[i].num);
    end
    chk("frame8_done", fd_cnt - fd0, 1);
    chk("frame8_err", fe_cnt - fe0, 0);

    // High-width decode table: first bit of each word carries the width
    clear_log();
    for (int i = 0; i < 8; i++) begin
      pulse(bv[i].hi, 6);
      for (int b = 22; b >= 0; b--) send_bit(PAT[b]);
    end
    gap();
    chk("width_writes", wr_data.size(), 8);
    for (int i = 0; i < 8 && i < wr_data.size(); i++)
      chk($sformatf("width_hi%0d", bv[i].hi), wr_data[i], {bv[i].bit_v, PAT});

    // Write latency: 3 clocks after the first low sample ending bit 24
    clear_log();
    lw = 24'h5A5A5B;
    for (int i = 23; i >= 1; i--) send_bit(lw[i]);
    din = 1'b1;
    repeat (10) @(negedge clk);
    din = 1'b0;
    repeat (3) @(negedge clk);
    chk("lat_early", write, 0);
    @(negedge clk);
    chk("lat_write", write, 1);
    chk("lat_data", rgb_data, 24'h5A5A5B);
    chk("lat_num", led_num, 0);
    @(negedge clk);
    chk("lat_strobe", write, 0);
    gap();

    // 3: hand-driven bits then a glitch
    clear_log();
    fe0 = fe_cnt; fd0 = fd_cnt;
    pulse(5, 6); pulse(11, 6); pulse(7, 6); pulse(8, 6);
    pulse(1, 10);
    chk("glitch_err", fe_cnt - fe0, 1);
    chk("glitch_unsynced", synced, 0);
    send_word(24'h123456);
    gap();
    chk("glitch_no_write", wr_data.size(), 0);
    chk("glitch_no_done", fd_cnt - fd0, 0);
    chk("glitch_resync", synced, 1);

    // 4: twelve words, only first eight written
    clear_log();
    fd0 = fd_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 12; i++) send_word(24'h010000 * (i + 1) + 24'h0000AB);
    gap();
    chk("w12_writes", wr_data.size(), 8);
    for (int i = 0; i < 8 && i < wr_data.size(); i++)
      chk($sformatf("w12_num%0d", i), wr_num[i], i);
    if (wr_data.size() >= 8) chk("w12_last_data", wr_data[7], 24'h0800AB);
    chk("w12_done", fd_cnt - fd0, 1);
    chk("w12_err", fe_cnt - fe0, 0);
    clear_log();
    send_word(24'hC0FFEE);
    gap();
    chk("next_frame_cnt", wr_data.size(), 1);
    if (wr_data.size() >= 1) begin
      chk("next_frame_num", wr_num[0], 0);
      chk("next_frame_data", wr_data[0], 24'hC0FFEE);
    end

    // 5: partial word at gap, then a stuck-high line
    clear_log();
    fd0 = fd_cnt; fe0 = fe_cnt; n = both_cnt;
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    gap();
    chk("partial_both", both_cnt - n, 1);
    chk("partial_err", fe_cnt - fe0, 1);
    chk("partial_no_write", wr_data.size(), 0);
    fe0 = fe_cnt; fd0 = fd_cnt;
    pulse(70, 4);
    chk("stuck_err", fe_cnt - fe0, 1);
    chk("stuck_unsynced", synced, 0);
    chk("stuck_no_done", fd_cnt - fd0, 0);
    gap();
    chk("stuck_resync", synced, 1);

    // 6: reset in the middle of bit 13
    clear_log();
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    din = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_rgb", rgb_data, 0);
    chk("midrst_synced", synced, 0);
    chk("midrst_flags", {write, frame_done, frame_err, led_num}, 0);
    reset_n = 1'b1;
    din = 1'b0;
    @(negedge clk);
    send_word(24'hFFFFFF);
    gap();
    chk("midrst_no_write", wr_data.size(), 0);
    chk("midrst_resync", synced, 1);
    send_word(24'h3C3C3C);
    gap();
    chk("midrst_cnt", wr_data.size(), 1);
    if (wr_data.size() >= 1) begin
      chk("midrst_num", wr_num[0], 0);
      chk("midrst_data", wr_data[0], 24'h3C3C3C);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
